// File: rtl/ramp_seq_pkg.sv
// Shared encodings for the two-channel DAC ramp sequencer: FSM states,
// ramp-unit status codes and status-word bit positions.
package ramp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_HOLD      = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

    localparam logic [1:0] RS_IDLE      = 2'b00;
    localparam logic [1:0] RS_UP        = 2'b01;
    localparam logic [1:0] RS_LEVEL     = 2'b10;
    localparam logic [1:0] RS_DOWN_DONE = 2'b11;

    localparam int STS_CH0_LSB = 0;
    localparam int STS_CH1_LSB = 4;
    localparam int STS_FAULT0  = 8;
    localparam int STS_FAULT1  = 9;

endpackage

// File: rtl/ramp_channel_fsm.sv
// One synth channel: reset release, ramp-up wait, run, ramp-down, hold/fault.
// Outputs change one clk after the qualifying input; no backpressure.
module ramp_channel_fsm #(
    parameter int TIMEOUT_CYCLES = 12500000,
    parameter int CNT_WIDTH      = 28
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       trigger,
    input  logic       abort,
    input  logic       ramp_enable,
    input  logic       ramp_down_req,
    input  logic [1:0] ramp_state,
    input  logic       clear_fault,
    output logic       synth_aresetn,
    output logic       start_ramp_down,
    output logic       seq_done,
    output logic       fault,
    output logic [2:0] state
);
    import ramp_seq_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    seq_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 seq_done_q, fault_q;
    logic                 stop_req, timeout;

    assign stop_req = abort | ~trigger | ramp_down_req;
    assign timeout  = (cnt_q >= CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (trigger && !abort)
                              state_d = ramp_enable ? ST_RAMP_UP : ST_RUN;
            // Reaching level wins over a stop request seen in the same cycle.
            ST_RAMP_UP:   if (ramp_state == RS_LEVEL) state_d = ST_RUN;
                          else if (stop_req)          state_d = ST_RAMP_DOWN;
                          else if (timeout)           state_d = ST_FAULT;
            ST_RUN:       if (stop_req)
                              state_d = ramp_enable ? ST_RAMP_DOWN : ST_HOLD;
            ST_RAMP_DOWN: if (ramp_state == RS_DOWN_DONE) state_d = ST_HOLD;
                          else if (timeout)               state_d = ST_FAULT;
            ST_HOLD:      if (!trigger) state_d = ST_IDLE;
            ST_FAULT:     if (clear_fault && !trigger) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if ((state_q == ST_RAMP_UP || state_q == ST_RAMP_DOWN) && cnt_q != '1)
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seq_done_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seq_done_q <= (state_d == ST_HOLD) && (state_q != ST_HOLD);
            fault_q    <= (state_d == ST_FAULT);
        end
    end

    assign synth_aresetn   = (state_q == ST_RAMP_UP) || (state_q == ST_RUN) ||
                             (state_q == ST_RAMP_DOWN);
    assign start_ramp_down = (state_q == ST_RAMP_DOWN);
    assign seq_done        = seq_done_q;
    assign fault           = fault_q;
    assign state           = state_q;

endmodule

// File: rtl/ramp_sequencer.sv
// Two independent synth-channel ramp sequencers plus packed status word.
// Outputs change one clk after the qualifying input; no backpressure.
module ramp_sequencer #(
    parameter int TIMEOUT_CYCLES = 12500000,
    parameter int CNT_WIDTH      = 28
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        trigger,
    input  logic        abort,
    input  logic [1:0]  ramp_enable,
    input  logic [1:0]  ramp_down_req,
    input  logic [1:0]  ramp_state_0,
    input  logic [1:0]  ramp_state_1,
    input  logic        clear_fault,
    output logic [1:0]  synth_aresetn,
    output logic [1:0]  start_ramp_down,
    output logic [1:0]  seq_done,
    output logic [1:0]  fault,
    output logic [15:0] seq_sts
);
    import ramp_seq_pkg::*;

    logic [2:0] st0, st1;

    ramp_channel_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_ch0 (
        .clk(clk), .areset(areset), .trigger(trigger), .abort(abort),
        .ramp_enable(ramp_enable[0]), .ramp_down_req(ramp_down_req[0]),
        .ramp_state(ramp_state_0), .clear_fault(clear_fault),
        .synth_aresetn(synth_aresetn[0]), .start_ramp_down(start_ramp_down[0]),
        .seq_done(seq_done[0]), .fault(fault[0]), .state(st0)
    );

    ramp_channel_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_ch1 (
        .clk(clk), .areset(areset), .trigger(trigger), .abort(abort),
        .ramp_enable(ramp_enable[1]), .ramp_down_req(ramp_down_req[1]),
        .ramp_state(ramp_state_1), .clear_fault(clear_fault),
        .synth_aresetn(synth_aresetn[1]), .start_ramp_down(start_ramp_down[1]),
        .seq_done(seq_done[1]), .fault(fault[1]), .state(st1)
    );

    always_comb begin
        seq_sts                   = '0;
        seq_sts[STS_CH0_LSB +: 3] = st0;
        seq_sts[STS_CH1_LSB +: 3] = st1;
        seq_sts[STS_FAULT0]       = fault[0];
        seq_sts[STS_FAULT1]       = fault[1];
    end

endmodule

// File: tb/tb_ramp_sequencer.sv
// Directed bench for ramp_sequencer with a short timeout.
module tb_ramp_sequencer;

    logic        clk = 1'b0;
    logic        areset;
    logic        trigger, abort, clear_fault;
    logic [1:0]  ramp_enable, ramp_down_req, ramp_state_0, ramp_state_1;
    logic [1:0]  synth_aresetn, start_ramp_down, seq_done, fault;
    logic [15:0] seq_sts;
    logic [23:0] obs, exp_v;
    int          checks = 0;
    int          errors = 0;

    ramp_sequencer #(.TIMEOUT_CYCLES(100), .CNT_WIDTH(28)) dut (
        .clk(clk), .areset(areset), .trigger(trigger), .abort(abort),
        .ramp_enable(ramp_enable), .ramp_down_req(ramp_down_req),
        .ramp_state_0(ramp_state_0), .ramp_state_1(ramp_state_1),
        .clear_fault(clear_fault), .synth_aresetn(synth_aresetn),
        .start_ramp_down(start_ramp_down), .seq_done(seq_done),
        .fault(fault), .seq_sts(seq_sts)
    );

    always #5 clk = ~clk;

    assign obs = {synth_aresetn, start_ramp_down, seq_done, fault, seq_sts};

    // Expected output vector: aresetn, start_ramp_down, seq_done, fault, status word.
    function automatic logic [23:0] ev(input logic [1:0] a, input logic [1:0] s,
                                       input logic [1:0] d, input logic [1:0] f,
                                       input logic [2:0] st0, input logic [2:0] st1);
        logic [15:0] sts;
        sts      = '0;
        sts[2:0] = st0;
        sts[6:4] = st1;
        sts[8]   = f[0];
        sts[9]   = f[1];
        return {a, s, d, f, sts};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; trigger = 1'b1; abort = 1'b0; clear_fault = 1'b0;
        ramp_enable = 2'b11; ramp_down_req = 2'b00; ramp_state_0 = 2'b00; ramp_state_1 = 2'b00;
        repeat (3) step();
        exp_v = '0; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_hold got %h exp %h", obs, exp_v); end
        trigger = 1'b0; areset = 1'b0;
        step();
        exp_v = '0; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_idle got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_ramped_cycle();
        ramp_enable = 2'b01; ramp_state_0 = 2'b01; trigger = 1'b1;
        step();
        exp_v = ev(2'b11, 2'b00, 2'b00, 2'b00, 3'd1, 3'd2); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rc_start got %h exp %h", obs, exp_v); end
        repeat (49) step();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rc_wait got %h exp %h", obs, exp_v); end
        ramp_state_0 = 2'b10;
        step();
        exp_v = ev(2'b11, 2'b00, 2'b00, 2'b00, 3'd2, 3'd2); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rc_level got %h exp %h", obs, exp_v); end
        trigger = 1'b0;
        step();
        exp_v = ev(2'b01, 2'b01, 2'b10, 2'b00, 3'd3, 3'd4); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rc_down got %h exp %h", obs, exp_v); end
        step();
        exp_v = ev(2'b01, 2'b01, 2'b00, 2'b00, 3'd3, 3'd0); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rc_ch1_idle got %h exp %h", obs, exp_v); end
        repeat (38) step();
        ramp_state_0 = 2'b11;
        step();
        exp_v = ev(2'b00, 2'b00, 2'b01, 2'b00, 3'd4, 3'd0); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rc_hold got %h exp %h", obs, exp_v); end
        step();
        exp_v = '0; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rc_idle got %h exp %h", obs, exp_v); end
        ramp_state_0 = 2'b00;
    endtask

    task automatic test_abort_ramp_up();
        ramp_enable = 2'b01; ramp_state_0 = 2'b01; trigger = 1'b1;
        step();
        exp_v = ev(2'b11, 2'b00, 2'b00, 2'b00, 3'd1, 3'd2); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ab_start got %h exp %h", obs, exp_v); end
        repeat (9) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_v = ev(2'b01, 2'b01, 2'b10, 2'b00, 3'd3, 3'd4); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ab_down got %h exp %h", obs, exp_v); end
        repeat (5) step();
        exp_v = ev(2'b01, 2'b01, 2'b00, 2'b00, 3'd3, 3'd4); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ab_down_wait got %h exp %h", obs, exp_v); end
        ramp_state_0 = 2'b11;
        step();
        exp_v = ev(2'b00, 2'b00, 2'b01, 2'b00, 3'd4, 3'd4); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ab_hold got %h exp %h", obs, exp_v); end
        repeat (3) step();
        exp_v = ev(2'b00, 2'b00, 2'b00, 2'b00, 3'd4, 3'd4); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ab_hold_trig got %h exp %h", obs, exp_v); end
        trigger = 1'b0; ramp_state_0 = 2'b00;
        step();
        exp_v = '0; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ab_idle got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_timeout();
        ramp_enable = 2'b01; ramp_state_0 = 2'b01; trigger = 1'b1;
        step();
        repeat (99) step();
        exp_v = ev(2'b11, 2'b00, 2'b00, 2'b00, 3'd1, 3'd2); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL to_pre got %h exp %h", obs, exp_v); end
        step();
        exp_v = ev(2'b10, 2'b00, 2'b00, 2'b01, 3'd5, 3'd2); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL to_fault got %h exp %h", obs, exp_v); end
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL to_clear_ignored got %h exp %h", obs, exp_v); end
        trigger = 1'b0;
        step();
        exp_v = ev(2'b00, 2'b00, 2'b10, 2'b01, 3'd5, 3'd4); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL to_trig_low got %h exp %h", obs, exp_v); end
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        exp_v = '0; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL to_cleared got %h exp %h", obs, exp_v); end
        ramp_state_0 = 2'b00;
    endtask

    task automatic test_simultaneous();
        ramp_enable = 2'b01; ramp_state_0 = 2'b01; trigger = 1'b1;
        repeat (3) step();
        ramp_state_0 = 2'b10; abort = 1'b1;
        step();
        exp_v = ev(2'b01, 2'b00, 2'b10, 2'b00, 3'd2, 3'd4); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sim_run got %h exp %h", obs, exp_v); end
        step();
        exp_v = ev(2'b01, 2'b01, 2'b00, 2'b00, 3'd3, 3'd4); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sim_down got %h exp %h", obs, exp_v); end
        abort = 1'b0; ramp_state_0 = 2'b11;
        step();
        exp_v = ev(2'b00, 2'b00, 2'b01, 2'b00, 3'd4, 3'd4); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sim_hold got %h exp %h", obs, exp_v); end
        trigger = 1'b0; ramp_state_0 = 2'b00;
        step();
        exp_v = '0; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL sim_idle got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_async_reset();
        ramp_enable = 2'b01; ramp_state_0 = 2'b01; trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
        exp_v = ev(2'b01, 2'b01, 2'b10, 2'b00, 3'd3, 3'd4); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ar_down got %h exp %h", obs, exp_v); end
        step();
        exp_v = ev(2'b01, 2'b01, 2'b00, 2'b00, 3'd3, 3'd0); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ar_down2 got %h exp %h", obs, exp_v); end
        #3 areset = 1'b1;
        #1;
        exp_v = '0; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ar_async got %h exp %h", obs, exp_v); end
        step();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ar_held got %h exp %h", obs, exp_v); end
        areset = 1'b0;
        step();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ar_idle got %h exp %h", obs, exp_v); end
        repeat (3) step();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ar_no_done got %h exp %h", obs, exp_v); end
        ramp_state_0 = 2'b00;
    endtask

    initial begin
        test_reset();
        test_ramped_cycle();
        test_abort_ramp_up();
        test_timeout();
        test_simultaneous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ramp_sequencer.md
Name: ramp_sequencer

Overview:
- Two-channel controller that sequences the Fourier-synth DAC outputs around the acquisition trigger.
- Per channel: releases the synth reset, waits for the ramp unit to reach full amplitude, runs, then requests a controlled ramp-down before re-asserting reset.
- Sits between the reset-manager trigger/instant-reset logic and the two ramping units. Replaces direct trigger-to-reset gating of the synth channels when ramping is configured.

Parameters:
- TIMEOUT_CYCLES, 12500000, maximum cycles allowed in a ramp-wait state (100 ms at 125 MHz) before FAULT.
- CNT_WIDTH, 28, width of each channel's timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  125 MHz ADC clock
- areset  in  1  asynchronous, active-high reset
- trigger  in  1  synchronised trigger state (1 = acquisition window active)
- abort  in  1  instant-reset request; synchronous level
- ramp_enable  in  2  per-channel ramping enable (bit n = channel n)
- ramp_down_req  in  2  software-requested ramp-down, level
- ramp_state_0  in  2  channel 0 ramp unit state: 00 idle, 01 ramping up, 10 at level, 11 ramp-down complete
- ramp_state_1  in  2  channel 1 ramp unit state, same encoding
- clear_fault  in  1  single-cycle pulse; clears sticky faults
- synth_aresetn  out  2  per-channel synth reset, active-low
- start_ramp_down  out  2  per-channel ramp-down command to the ramp unit
- seq_done  out  2  one-cycle pulse when a channel enters HOLD
- fault  out  2  sticky per-channel timeout flag
- seq_sts  out  16  [2:0] ch0 state, [6:4] ch1 state, [8] fault0, [9] fault1, others 0

Behaviour:
- Reset (areset=1, async): both channels go to IDLE. synth_aresetn=00, start_ramp_down=00, seq_done=00, fault=00, counters 0. Reset mid-ramp abandons the ramp immediately.
- All outputs are registered and decoded from the state register. There is no combinational path from inputs to outputs.
- State encoding (shared package): IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, HOLD=4, FAULT=5.
- IDLE:
  - Outputs: aresetn=0, start_ramp_down=0.
  - If trigger=1 and abort=0: go to RAMP_UP when ramp_enable[n]=1, otherwise RUN.
- RAMP_UP:
  - Outputs: aresetn=1, counter increments each cycle.
  - ramp_state=10: go to RUN, counter cleared.
  - Else if abort=1, trigger=0 or ramp_down_req[n]=1: go to RAMP_DOWN, counter cleared.
  - Else if counter reaches TIMEOUT_CYCLES-1: go to FAULT.
  - Completion has priority over abort in the same cycle.
- RUN:
  - Outputs: aresetn=1.
  - On abort, trigger=0 or ramp_down_req[n]: go to RAMP_DOWN if ramp_enable[n]=1, otherwise HOLD.
- RAMP_DOWN:
  - Outputs: aresetn=1, start_ramp_down=1, counter increments.
  - ramp_state=11: go to HOLD.
  - Timeout: go to FAULT.
  - abort has no further effect here.
- HOLD:
  - Outputs: aresetn=0, start_ramp_down=0.
  - seq_done[n] pulses on the entry cycle.
  - Stays in HOLD while trigger=1, so there is no restart within the same trigger window. Goes to IDLE when trigger=0.
- FAULT:
  - Outputs: aresetn=0, start_ramp_down=0, fault[n]=1 (set on the entry cycle).
  - clear_fault with trigger=0: go to IDLE, fault[n] cleared.
  - clear_fault with trigger=1: ignored.
- Latency: the output reflects the new state one clk after the qualifying input is sampled.
- Channels are fully independent. Simultaneous events on both channels are handled in parallel with no arbitration.
- ramp_enable changing mid-sequence is sampled only at the IDLE and RUN decision points.
- The counter saturates and never wraps. It is cleared on every state change.

Decomposition:
- Package ramp_seq_pkg:
  - state encoding constants.
  - ramp_state codes (RS_IDLE, RS_UP, RS_LEVEL, RS_DOWN_DONE).
  - seq_sts bit positions.
- Sub-module ramp_channel_fsm:
  - one channel's FSM, counter and output registers.
  - instantiated twice by ramp_sequencer, which only packs the status word.

Test Plan:
- Ramped cycle, ch0:
  - Stimulus: ramp_enable=01, raise trigger, ramp_state_0=10 after 50 cycles, drop trigger, ramp_state_0=11 after 40 cycles.
  - Response: synth_aresetn[0]=1 one cycle after trigger; start_ramp_down[0]=1 one cycle after trigger falls; HOLD with seq_done[0] pulse; IDLE next cycle; ch1 goes RUN then HOLD with no ramp-down.
- Abort during RAMP_UP:
  - Stimulus: trigger=1, abort pulse at cycle 10.
  - Response: RAMP_DOWN; start_ramp_down=1 until ramp_state=11; HOLD held while trigger=1.
- Timeout (TIMEOUT_CYCLES=100 in bench):
  - Stimulus: ramp_state held at 01.
  - Response: FAULT at cycle 100, fault[0]=1, aresetn=0.
  - clear_fault while trigger=1: no change.
  - clear_fault after trigger=0: IDLE, fault=0.
- Simultaneous events:
  - Stimulus: ramp_state=10 and abort asserted in the same cycle.
  - Response: RUN, then RAMP_DOWN on the next cycle.
- Async reset mid-RAMP_DOWN:
  - Stimulus: assert areset between clock edges.
  - Response: all outputs 0 immediately; IDLE after release; no spurious seq_done.
